// File: rtl/omap_wr_biu_pkg.sv
// Shared types and constants for the output-feature-map write BIU.
package omap_wr_biu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TOTAL_W = 24;

  function automatic int byte_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/omap_wr_biu_if.sv
// Merger stream, arbiter write request and write response signals of the BIU.
interface omap_wr_biu_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          merger_vld;
  logic          merger_rdy;
  logic [DW-1:0] merger_data;
  logic          arb_req;
  logic          arb_vld;
  logic          arb_rdy;
  logic [AW-1:0] arb_addr;
  logic [DW-1:0] arb_data;
  logic          rsp_vld;
  logic          rsp_rdy;

  modport master (
    input  merger_vld, merger_data, arb_rdy, rsp_vld,
    output merger_rdy, arb_req, arb_vld, arb_addr, arb_data, rsp_rdy
  );

  modport slave (
    output merger_vld, merger_data, arb_rdy, rsp_vld,
    input  merger_rdy, arb_req, arb_vld, arb_addr, arb_data, rsp_rdy
  );
endinterface

// File: rtl/omap_wr_fifo.sv
// Small synchronous FIFO between merger and arbiter; head word read from flops.
module omap_wr_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  // No write-through: a push is refused while full even if a pop happens.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign full_o     = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/omap_wr_biu.sv
// Output-feature-map write BIU: job FSM, word/response counters and outstanding window.
module omap_wr_biu
  import omap_wr_biu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] omap_base_addr_i,
  input  logic [15:0]   map_size_i,
  input  logic [7:0]    out_ch_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rsp_err_o,
  omap_wr_biu_if.master bus
);
  localparam int              SHIFT     = byte_shift(DW);
  localparam int              OW        = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);

  state_e               state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [TOTAL_W-1:0]   total_q, total_d, start_total;
  logic [TOTAL_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [TOTAL_W-1:0]   sent_cnt_q, sent_cnt_d;
  logic [TOTAL_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 fifo_full, fifo_empty;
  logic [DW-1:0]        fifo_data;
  logic                 in_job, acc_hs, arb_hs, rsp_hs, rsp_ok;

  assign in_job      = (state_q == RUN) || (state_q == DRAIN);
  assign busy_o      = in_job;
  assign done_o      = (state_q == DONE);
  assign rsp_err_o   = rsp_err_q;
  assign start_total = TOTAL_W'(map_size_i) * TOTAL_W'(out_ch_i);

  assign bus.arb_req    = in_job;
  assign bus.merger_rdy = (state_q == RUN) && !fifo_full && (acc_cnt_q < total_q);
  // arb_vld cannot drop mid-stall: outst only grows and the FIFO only drains on a handshake.
  assign bus.arb_vld    = (state_q == RUN) && !fifo_empty && (outst_q < OUTST_MAX);
  assign bus.arb_addr   = base_q + (AW'(sent_cnt_q) << SHIFT);
  assign bus.arb_data   = fifo_data;
  assign bus.rsp_rdy    = 1'b1;

  assign acc_hs = bus.merger_vld && bus.merger_rdy;
  assign arb_hs = bus.arb_vld && bus.arb_rdy;
  assign rsp_hs = bus.rsp_vld && in_job;
  assign rsp_ok = rsp_hs && (outst_q != '0);

  omap_wr_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (acc_hs),
    .push_data_i (bus.merger_data),
    .pop_i       (arb_hs),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    total_d    = total_q;
    acc_cnt_d  = acc_cnt_q + TOTAL_W'(acc_hs);
    sent_cnt_d = sent_cnt_q + TOTAL_W'(arb_hs);
    rcv_cnt_d  = rcv_cnt_q + TOTAL_W'(rsp_ok);
    rsp_err_d  = rsp_err_q | (rsp_hs & ~rsp_ok);
    case ({arb_hs, rsp_ok})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = omap_base_addr_i;
          total_d    = start_total;
          acc_cnt_d  = '0;
          sent_cnt_d = '0;
          rcv_cnt_d  = '0;
          outst_d    = '0;
          rsp_err_d  = 1'b0;
          state_d    = (start_total == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (arb_hs && (sent_cnt_q == total_q - TOTAL_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (rcv_cnt_d == total_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
      rcv_cnt_q  <= '0;
      outst_q    <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      outst_q    <= outst_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Job parameters are only meaningful once a start has latched them.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    total_q <= total_d;
  end

endmodule

// File: tb/tb_omap_wr_biu.sv
// Randomized self-checking bench for omap_wr_biu with a word-list reference model.
module tb_omap_wr_biu;
  localparam int DW = 32, AW = 32, FIFO_DEPTH = 4, MAX_OUTST = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [15:0]   ms = '0;
  logic [7:0]    oc = '0;
  logic          busy, done, rsp_err;

  omap_wr_biu_if #(.DW(DW), .AW(AW)) bus ();

  omap_wr_biu #(.DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .omap_base_addr_i (base_in),
    .map_size_i       (ms),
    .out_ch_i         (oc),
    .busy_o           (busy),
    .done_o           (done),
    .rsp_err_o        (rsp_err),
    .bus              (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  logic [AW-1:0] job_base;
  int            job_total;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [DW-1:0] offer_data[$];
  int acc_n, stall_viol, full_viol, cap_viol, over_acc, rdy_bad;
  int done_cyc, last_rsp_cyc;
  bit done_busy, timed_out;

  task automatic zero_inputs();
    bus.merger_vld = 1'b0; bus.merger_data = '0; bus.arb_rdy = 1'b0; bus.rsp_vld = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; zero_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int m, input int o);
    @(negedge clk);
    base_in = b; ms = m[15:0]; oc = o[7:0]; start = 1'b1;
    job_base = b; job_total = m * o;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Drives merger, arbiter and response sides and records what crossed the bus.
  task automatic run_job(input int n_offer, input int vld_pct, input int rdy_pct, input int rsp_dly,
                         input bit drain_start, input int stop_after);
    int cyc = 0, sent = 0, rcvd = 0, offered = 0, last_due = 0;
    int due_q[$];
    bit cur_vld = 0, prev_stall = 0, drain_pulsed = 0;
    logic [DW-1:0] cur_data = '0, prev_data = '0;
    logic [AW-1:0] prev_addr = '0;
    wr_addr.delete(); wr_data.delete(); offer_data.delete();
    acc_n = 0; stall_viol = 0; full_viol = 0; cap_viol = 0; over_acc = 0; rdy_bad = 0;
    done_cyc = -1; last_rsp_cyc = -100; done_busy = 1'b1; timed_out = 1'b0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (!cur_vld && offered < n_offer && $urandom_range(99) < vld_pct) begin
        cur_vld = 1; cur_data = $urandom; offer_data.push_back(cur_data); offered++;
      end
      bus.merger_vld  = cur_vld;
      bus.merger_data = cur_data;
      bus.arb_rdy     = ($urandom_range(99) < rdy_pct);
      bus.rsp_vld     = (due_q.size() > 0 && due_q[0] <= cyc);
      if (drain_start && !drain_pulsed && sent == job_total) begin
        drain_pulsed = 1; start = 1'b1; base_in = 32'hDEAD_0000; ms = 16'd3; oc = 8'd1;
      end
      #1;
      if (prev_stall && !(bus.arb_vld === 1'b1 && bus.arb_addr === prev_addr && bus.arb_data === prev_data))
        stall_viol++;
      if (bus.merger_rdy && (acc_n - sent) >= FIFO_DEPTH) full_viol++;
      if (bus.merger_rdy && acc_n >= job_total) over_acc++;
      if (bus.arb_vld && (sent - rcvd) >= MAX_OUTST) cap_viol++;
      if (bus.rsp_rdy !== 1'b1) rdy_bad++;
      if (cur_vld && bus.merger_rdy) begin acc_n++; cur_vld = 0; end
      if (bus.arb_vld && bus.arb_rdy) begin
        wr_addr.push_back(bus.arb_addr); wr_data.push_back(bus.arb_data); sent++;
        last_due = (cyc + rsp_dly > last_due) ? cyc + rsp_dly : last_due;
        due_q.push_back(last_due);
      end
      if (bus.rsp_vld) begin void'(due_q.pop_front()); rcvd++; last_rsp_cyc = cyc; end
      prev_stall = bus.arb_vld && !bus.arb_rdy;
      prev_addr  = bus.arb_addr;
      prev_data  = bus.arb_data;
      if (done) begin done_cyc = cyc; done_busy = busy; zero_inputs(); return; end
      cyc++;
      if (stop_after > 0 && sent >= stop_after) begin zero_inputs(); return; end
      if (cyc > 3000) begin timed_out = 1'b1; zero_inputs(); return; end
    end
  endtask

  task automatic test_reset();
    zero_inputs(); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
    n_chk++; if (bus.arb_req !== 1'b0) $display("FAIL reset_arb_req: got %b want 0", bus.arb_req); else n_pass++;
    n_chk++; if (bus.arb_vld !== 1'b0) $display("FAIL reset_arb_vld: got %b want 0", bus.arb_vld); else n_pass++;
    n_chk++; if (bus.merger_rdy !== 1'b0) $display("FAIL reset_merger_rdy: got %b want 0", bus.merger_rdy); else n_pass++;
    n_chk++; if (bus.rsp_rdy !== 1'b1) $display("FAIL reset_rsp_rdy: got %b want 1", bus.rsp_rdy); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start_job(32'h1000, 4, 2);
    n_chk++; if (busy !== 1'b1 || bus.arb_req !== 1'b1)
      $display("FAIL basic_start: busy=%b arb_req=%b want 1/1", busy, bus.arb_req); else n_pass++;
    run_job(8, 100, 100, 2, 0, 0);
    n_chk++; if (timed_out || wr_addr.size() != 8)
      $display("FAIL basic_count: got %0d writes (timeout=%b) want 8", wr_addr.size(), timed_out); else n_pass++;
    for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
      n_chk++; if (wr_addr[i] !== 32'h1000 + 32'(4 * i) || wr_data[i] !== offer_data[i])
        $display("FAIL basic_word%0d: addr %h data %h want %h %h", i, wr_addr[i], wr_data[i],
                 32'h1000 + 32'(4 * i), offer_data[i]);
      else n_pass++;
    end
    n_chk++; if (done_cyc != last_rsp_cyc + 1 || done_busy !== 1'b0)
      $display("FAIL basic_done: done at %0d busy %b, want %0d busy 0", done_cyc, done_busy, last_rsp_cyc + 1);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0/0", done, busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] b;
    int bad = 0;
    b = $urandom & 32'hFFFF_FFFC;
    start_job(b, 37, 1);
    run_job(37, 60, 50, $urandom_range(1, 4), 0, 0);
    n_chk++; if (timed_out || wr_addr.size() != 37 || acc_n != 37)
      $display("FAIL bp_count: writes %0d accepted %0d timeout %b want 37/37", wr_addr.size(), acc_n, timed_out);
    else n_pass++;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== b + 32'(4 * i) || wr_data[i] !== offer_data[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL bp_order: %0d words wrong want 0", bad); else n_pass++;
    n_chk++; if (stall_viol != 0) $display("FAIL bp_stable: %0d unstable stalls want 0", stall_viol); else n_pass++;
    n_chk++; if (full_viol != 0) $display("FAIL bp_full_rdy: %0d rdy while full want 0", full_viol); else n_pass++;
    n_chk++; if (cap_viol != 0 || rdy_bad != 0)
      $display("FAIL bp_cap: cap %0d rsp_rdy %0d want 0/0", cap_viol, rdy_bad); else n_pass++;
    n_chk++; if (done_cyc != last_rsp_cyc + 1)
      $display("FAIL bp_done: done at %0d want %0d", done_cyc, last_rsp_cyc + 1); else n_pass++;
  endtask

  task automatic test_outst_cap();
    int hs = 0;
    start_job(32'h8000, 20, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.merger_vld = 1'b1; bus.merger_data = $urandom; bus.arb_rdy = 1'b1; bus.rsp_vld = 1'b0;
      #1;
      if (bus.arb_vld) hs++;
    end
    n_chk++; if (hs != MAX_OUTST) $display("FAIL cap_count: got %0d writes want %0d", hs, MAX_OUTST); else n_pass++;
    n_chk++; if (bus.arb_vld !== 1'b0) $display("FAIL cap_vld: got %b want 0", bus.arb_vld); else n_pass++;
    @(negedge clk); bus.rsp_vld = 1'b1; #1;
    @(negedge clk); bus.rsp_vld = 1'b0; #1;
    n_chk++; if (bus.arb_vld !== 1'b1 || bus.arb_addr !== 32'h8000 + 32'(4 * MAX_OUTST))
      $display("FAIL cap_resume: vld %b addr %h want 1 %h", bus.arb_vld, bus.arb_addr, 32'h8000 + 32'(4 * MAX_OUTST));
    else n_pass++;
    if (bus.arb_vld) hs++;
    repeat (4) begin @(negedge clk); #1; if (bus.arb_vld) hs++; end
    n_chk++; if (hs != MAX_OUTST + 1 || bus.arb_vld !== 1'b0)
      $display("FAIL cap_one_more: %0d writes vld %b want %0d 0", hs, bus.arb_vld, MAX_OUTST + 1); else n_pass++;
    do_reset();
  endtask

  task automatic test_zero_stray();
    @(negedge clk); bus.rsp_vld = 1'b1;
    @(negedge clk); bus.rsp_vld = 1'b0; #1;
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL idle_stray: rsp_err %b want 0", rsp_err); else n_pass++;
    start_job(32'h3000, 5, 0);
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || bus.arb_vld !== 1'b0 || bus.arb_req !== 1'b0)
      $display("FAIL zero_done: done %b busy %b vld %b req %b want 1 0 0 0", done, busy, bus.arb_vld, bus.arb_req);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (done !== 1'b0) $display("FAIL zero_pulse: done %b want 0", done); else n_pass++;
    start_job(32'h3100, 2, 1);
    bus.rsp_vld = 1'b1;
    @(negedge clk); bus.rsp_vld = 1'b0; #1;
    n_chk++; if (rsp_err !== 1'b1) $display("FAIL run_stray: rsp_err %b want 1", rsp_err); else n_pass++;
    run_job(2, 100, 100, 1, 0, 0);
    n_chk++; if (timed_out || wr_addr.size() != 2 || done_cyc != last_rsp_cyc + 1)
      $display("FAIL stray_job: writes %0d done %0d want 2 at %0d", wr_addr.size(), done_cyc, last_rsp_cyc + 1);
    else n_pass++;
    n_chk++; if (rsp_err !== 1'b1) $display("FAIL err_sticky: rsp_err %b want 1", rsp_err); else n_pass++;
    start_job(32'h3200, 1, 1);
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL err_clear: rsp_err %b want 0", rsp_err); else n_pass++;
    run_job(1, 100, 100, 1, 0, 0);
  endtask

  task automatic test_excess_restart();
    int bad = 0;
    start_job(32'h4000, 8, 1);
    run_job(10, 100, 100, 3, 1, 0);
    n_chk++; if (acc_n != 8 || over_acc != 0)
      $display("FAIL excess_accept: accepted %0d rdy-past-total %0d want 8/0", acc_n, over_acc); else n_pass++;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'h4000 + 32'(4 * i) || wr_data[i] !== offer_data[i]) bad++;
    n_chk++; if (timed_out || wr_addr.size() != 8 || bad != 0)
      $display("FAIL excess_writes: %0d writes %0d wrong want 8/0", wr_addr.size(), bad); else n_pass++;
    n_chk++; if (done_cyc != last_rsp_cyc + 1)
      $display("FAIL excess_done: done at %0d want %0d", done_cyc, last_rsp_cyc + 1); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (busy !== 1'b0 || bus.arb_vld !== 1'b0)
      $display("FAIL drain_start_ignored: busy %b vld %b want 0/0", busy, bus.arb_vld); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_job(32'h1000, 8, 1);
    run_job(8, 100, 100, 2, 0, 3);
    n_chk++; if (wr_addr.size() != 3) $display("FAIL mid_pre: %0d writes want 3", wr_addr.size()); else n_pass++;
    @(negedge clk); rst_n = 1'b0; zero_inputs();
    @(negedge clk); #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || rsp_err !== 1'b0 || bus.arb_req !== 1'b0 ||
                 bus.arb_vld !== 1'b0 || bus.merger_rdy !== 1'b0)
      $display("FAIL mid_reset: busy %b done %b err %b req %b vld %b mrdy %b want all 0",
               busy, done, rsp_err, bus.arb_req, bus.arb_vld, bus.merger_rdy);
    else n_pass++;
    rst_n = 1'b1;
    start_job(32'h2000, 4, 1);
    run_job(4, 100, 100, 2, 0, 0);
    n_chk++; if (wr_addr.size() < 1 || wr_addr[0] !== 32'h2000 || wr_data[0] !== offer_data[0])
      $display("FAIL mid_restart_first: %0d writes first addr %h want 32'h2000", wr_addr.size(),
               (wr_addr.size() > 0) ? wr_addr[0] : 32'h0);
    else n_pass++;
    n_chk++; if (timed_out || wr_addr.size() != 4 || wr_addr[3] !== 32'h200C || done_cyc != last_rsp_cyc + 1)
      $display("FAIL mid_restart_job: %0d writes done %0d want 4 at %0d", wr_addr.size(), done_cyc, last_rsp_cyc + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_outst_cap();
    test_zero_stray();
    test_excess_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/omap_wr_biu.md
# omap_wr_biu

Parametrised output-feature-map write bus interface unit between the map merger and the memory arbiter. It accepts a job (base address, map size, output channel count) and buffers merger words in a small FIFO. It issues sequential word writes to the arbiter, bounds the number of writes awaiting response, and pulses `done` when every response for the job has returned. It replaces the fixed-size, fixed-width output BIU with a runtime-sized, flow-controlled job engine.

## Interface
- `DW`, 32, data word width in bits; multiple of 8, power of two.
- `AW`, 32, address width.
- `FIFO_DEPTH`, 4, merger-to-arbiter buffer depth in words; power of two, ≥2.
- `MAX_OUTST`, 16, maximum write requests awaiting response; ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `omap_base_addr`  in  AW  job base byte address; latched on start.
- `map_size`  in  16  words per output channel; latched on start.
- `out_ch`  in  8  output channel count; latched on start.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle job-complete pulse.
- `rsp_err`  out  1  sticky: response received with zero outstanding; cleared on accepted start.
- `merger_vld` / `merger_rdy` / `merger_data`  in / out / in  1/1/DW  input word stream.
- `arb_req`  out  1  bus ownership request to arbiter.
- `arb_vld` / `arb_rdy`  out / in  1/1  write request handshake.
- `arb_addr`  out  AW  write byte address.
- `arb_data`  out  DW  write data.
- `rsp_vld` / `rsp_rdy`  in / out  1/1  write response handshake; `rsp_rdy` tied 1.

## Operation
- Reset values: state IDLE; `busy`, `done`, `rsp_err`, `arb_req`, `arb_vld`, `merger_rdy` = 0; all counters 0; FIFO empty.
- `total` = `map_size` × `out_ch`, 24-bit unsigned, latched on start.
- FSM states:
  - IDLE: on `start`, latch inputs, clear counters and `rsp_err`. If `total`==0, go to DONE; otherwise go to RUN.
  - RUN: advance to DRAIN on the arb handshake of word `total`−1.
  - DRAIN: advance to DONE on the cycle the response count reaches `total`.
  - DONE: `done`=1 for one cycle, then IDLE.
- `arb_req` = 1 in RUN and DRAIN, 0 otherwise.
- `acc_cnt` counts merger handshakes. `merger_rdy` = RUN ∧ FIFO not full ∧ `acc_cnt` < `total`. Words beyond `total` are never accepted.
- `sent_cnt` counts arb handshakes. `arb_addr` = base + `sent_cnt` × (DW/8), implemented as a shift, truncated mod 2^AW (wraps silently).
- `arb_vld` = FIFO not empty ∧ `outst` < `MAX_OUTST`. Once asserted, `arb_vld`, `arb_addr` and `arb_data` hold stable until `arb_rdy`.
- `outst`: +1 on arb handshake, −1 on response handshake. Both in the same cycle leave it unchanged. A response with `outst`==0 sets `rsp_err` and is not counted.
- `rcv_cnt` counts valid responses; responses arriving in IDLE or DONE count nowhere.
- `start` is ignored outside IDLE.
- Reset asserted mid-job aborts immediately to reset values. In-flight bus transactions are discarded.

## Timing
- Job start: `start` at cycle t gives `busy`=`arb_req`=1 and `merger_rdy` eligible at t+1.
- FIFO latency: a word accepted at cycle t can present `arb_vld` at t+1 (no bypass). Full FIFO throughput is one word per cycle.
- FIFO full ∧ pop in the same cycle: `merger_rdy` stays 0; the push is permitted only when the FIFO is not full (no write-through).
- Outstanding stall: at `outst`==`MAX_OUTST`, `arb_vld` drops in the cycle after the handshake that filled the window. It reasserts the cycle after a response.
- Completion: the last response handshake at cycle t gives `done`=1 and `busy`=0 at t+1, with IDLE at t+2. A new `start` is accepted at t+2.
- `total`==0: `start` at t gives `done` at t+1 with no bus activity.

## Structure
- Package `omap_wr_biu_pkg` holds:
  - FSM state typedef (IDLE, RUN, DRAIN, DONE);
  - 24-bit `total` width constant;
  - byte-shift helper constant log2(DW/8).
- One sub-module, `omap_wr_fifo`: synchronous FIFO, DW × FIFO_DEPTH, registered output, full/empty flags, synchronous active-low reset.
- Counters and FSM live in the top module.

## Test plan
- Basic job: `map_size`=4, `out_ch`=2, base 0x1000, arbiter always ready, response 2 cycles after each request. Expect 8 writes to 0x1000–0x101C in step 4, data in order, then `done` one cycle after the 8th response.
- Backpressure: `arb_rdy` toggling pseudo-randomly, merger bursty, `total`=37. Expect `arb_addr`/`arb_data` stable while stalled, no word lost or duplicated, and `merger_rdy`=0 whenever the FIFO is full.
- Outstanding cap: `MAX_OUTST`=16, responses withheld. Expect exactly 16 handshakes then `arb_vld`=0; releasing one response resumes one write.
- Zero size with a stray response: `out_ch`=0 gives `done` at t+1 with no `arb_vld`. A `rsp_vld` pulse in IDLE leaves the counters unchanged; a `rsp_vld` pulse in RUN with `outst`==0 sets `rsp_err`.
- Excess input and restart: the merger offers 10 words for `total`=8. Expect 8 accepted, `merger_rdy`=0 after that, and a `start` during DRAIN ignored.
- Reset mid-job: `rst_n`=0 after 3 writes. Expect all outputs at reset values next cycle, and a new job from base 0x2000 starting at `sent_cnt`=0.
